// File: rtl/mc_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-style control unit:
// FSM state enumeration, opcode/funct constants, ALU operation codes,
// ALU operand-B and PC-source select encodings, and the control bundle struct.
package mc_control_unit_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTEXE, RTWB, IMMEXE, IMMWB, BRANCH, JUMP
  } state_e;

  // Opcodes (instruction bits [31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FN_W-1:0] FN_NOR = 6'b100111;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

  // ALU operand-B select
  localparam logic [SRCB_W-1:0] SRCB_REG   = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [PCSRC_W-1:0] PC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_JUMP   = 2'b10;

  // Full set of control outputs driven toward the datapath
  typedef struct packed {
    logic [ALU_W-1:0]   alu_ctl;
    logic               alu_src_a;
    logic [SRCB_W-1:0]  alu_src_b;
    logic [PCSRC_W-1:0] pc_src;
    logic               pc_en;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Controller <-> datapath bundle.
// master (controller): receives Opcode, Funct, isZero, memReady; drives all
// datapath selects/enables and the Illegal pulse. slave is the datapath view.
interface mc_control_unit_if;
  import mc_control_unit_pkg::*;

  logic [OP_W-1:0]    Opcode;
  logic [FN_W-1:0]    Funct;
  logic               isZero;
  logic               memReady;
  logic [ALU_W-1:0]   ALUcontrol;
  logic               ALUSrcA;
  logic [SRCB_W-1:0]  ALUSrcB;
  logic [PCSRC_W-1:0] PCSrc;
  logic               PCEn;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               Illegal;

  modport master (
    input  Opcode, Funct, isZero, memReady,
    output ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal
  );

  modport slave (
    output Opcode, Funct, isZero, memReady,
    input  ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal
  );

endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational R-type funct -> ALU operation decode.
// funct_i: instruction bits [5:0]; alu_ctl_o: ALU code (AND for unknown);
// illegal_o: funct not in the supported set.
module alu_decoder
  import mc_control_unit_pkg::*;
(
  input  logic [FN_W-1:0]  funct_i,
  output logic [ALU_W-1:0] alu_ctl_o,
  output logic             illegal_o
);

  always_comb begin
    alu_ctl_o = ALU_AND;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_ctl_o = ALU_ADD;
      FN_SUB:  alu_ctl_o = ALU_SUB;
      FN_AND:  alu_ctl_o = ALU_AND;
      FN_OR:   alu_ctl_o = ALU_OR;
      FN_SLT:  alu_ctl_o = ALU_SLT;
      FN_NOR:  alu_ctl_o = ALU_NOR;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control unit (Moore FSM).
// clk, rst_n: clock and asynchronous active-low reset.
// bus (master): Opcode/Funct/isZero/memReady in; ALU selects, PC/memory/
// register-file enables and the Illegal pulse out, decoded from state with
// PCEn/IRWrite additionally gated by memReady/isZero.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter bit HAS_MEM_READY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_unit_if.master bus
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;    // opcode captured in DECODE
  logic [ALU_W-1:0] alu_q, alu_d;  // R-type ALU code captured in RTEXE
  logic [ALU_W-1:0] dec_alu_c;
  logic             dec_illegal_c;
  logic             mem_rdy_c;
  ctrl_t            ctl_c;

  assign mem_rdy_c = HAS_MEM_READY ? bus.memReady : 1'b1;

  alu_decoder u_alu_dec (
    .funct_i   (bus.Funct),
    .alu_ctl_o (dec_alu_c),
    .illegal_o (dec_illegal_c)
  );

  // State and captured-instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    alu_d   = alu_q;
    ctl_c   = '0;
    case (state_q)
      FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.alu_ctl   = ALU_ADD;
        ctl_c.pc_src    = PC_ALU;
        // rst_n gate keeps the enables low while reset holds FETCH
        ctl_c.ir_write  = mem_rdy_c & rst_n;
        ctl_c.pc_en     = mem_rdy_c & rst_n;
        if (mem_rdy_c) state_d = DECODE;
      end
      DECODE: begin
        ctl_c.alu_src_b = SRCB_IMMSH;
        ctl_c.alu_ctl   = ALU_ADD;
        op_d            = bus.Opcode;
        case (bus.Opcode)
          OP_LW, OP_SW:    state_d = MEMADR;
          OP_RTYPE:        state_d = RTEXE;
          OP_ADDI, OP_ORI: state_d = IMMEXE;
          OP_BEQ:          state_d = BRANCH;
          OP_J:            state_d = JUMP;
          default: begin
            ctl_c.illegal = 1'b1;
            state_d       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_ctl   = ALU_ADD;
        state_d         = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.i_or_d   = 1'b1;
        if (mem_rdy_c) state_d = MEMWB;
      end
      MEMWB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 1'b1;
        state_d          = FETCH;
      end
      MEMWR: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.i_or_d    = 1'b1;
        state_d         = FETCH;
      end
      RTEXE: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REG;
        ctl_c.alu_ctl   = dec_alu_c;
        alu_d           = dec_alu_c;
        if (dec_illegal_c) begin
          ctl_c.illegal = 1'b1;
          state_d       = FETCH;
        end else begin
          state_d = RTWB;
        end
      end
      RTWB: begin
        ctl_c.reg_write = 1'b1;
        ctl_c.reg_dst   = 1'b1;
        ctl_c.alu_ctl   = alu_q;
        state_d         = FETCH;
      end
      IMMEXE: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_ctl   = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
        state_d         = IMMWB;
      end
      IMMWB: begin
        ctl_c.reg_write = 1'b1;
        state_d         = FETCH;
      end
      BRANCH: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REG;
        ctl_c.alu_ctl   = ALU_SUB;
        ctl_c.pc_src    = PC_ALUOUT;
        ctl_c.pc_en     = bus.isZero;
        state_d         = FETCH;
      end
      JUMP: begin
        ctl_c.pc_src = PC_JUMP;
        ctl_c.pc_en  = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.ALUcontrol = ctl_c.alu_ctl;
  assign bus.ALUSrcA    = ctl_c.alu_src_a;
  assign bus.ALUSrcB    = ctl_c.alu_src_b;
  assign bus.PCSrc      = ctl_c.pc_src;
  assign bus.PCEn       = ctl_c.pc_en;
  assign bus.IorD       = ctl_c.i_or_d;
  assign bus.MemRead    = ctl_c.mem_read;
  assign bus.MemWrite   = ctl_c.mem_write;
  assign bus.IRWrite    = ctl_c.ir_write;
  assign bus.RegDst     = ctl_c.reg_dst;
  assign bus.MemtoReg   = ctl_c.mem_to_reg;
  assign bus.RegWrite   = ctl_c.reg_write;
  assign bus.Illegal    = ctl_c.illegal;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: each instruction is expanded into
// a per-cycle plan of instruction phases, and every cycle the full control
// vector is compared against values derived from the phase rules.
module tb_mc_control_unit;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcen, iord, mrd, mwr, irw, regdst, m2r, rw, ill;
  } ctl_t;

  // Instruction phases as seen from outside the controller
  typedef enum int {
    K_IF_WAIT, K_IF, K_ID, K_MA, K_MR_WAIT, K_MR, K_MWB,
    K_SW, K_EX, K_RW, K_IE, K_IW, K_BR, K_JP
  } step_e;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  int    n_cmp = 0;
  int    n_bad = 0;
  step_e plan[$];

  mc_control_unit_if bus ();

  mc_control_unit #(.HAS_MEM_READY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  endfunction

  function automatic bit op_ok(input logic [5:0] opc);
    return opc inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001101, 6'b000100, 6'b000010};
  endfunction

  // Expected control vector for one phase
  function automatic ctl_t exp_of(input step_e k, input logic [5:0] opc, input logic [5:0] fn,
                                  input logic z);
    ctl_t e = '0;
    case (k)
      K_IF_WAIT, K_IF: begin
        e.mrd = 1'b1; e.srcb = 2'b01; e.alu = 4'b0010;
        e.irw = (k == K_IF); e.pcen = (k == K_IF);
      end
      K_ID: begin e.srcb = 2'b11; e.alu = 4'b0010; e.ill = !op_ok(opc); end
      K_MA: begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = 4'b0010; end
      K_MR_WAIT, K_MR: begin e.mrd = 1'b1; e.iord = 1'b1; end
      K_MWB: begin e.rw = 1'b1; e.m2r = 1'b1; end
      K_SW: begin e.mwr = 1'b1; e.iord = 1'b1; end
      K_EX: begin e.srca = 1'b1; e.srcb = 2'b00; e.alu = alu_of(fn); e.ill = !fn_ok(fn); end
      K_RW: begin e.rw = 1'b1; e.regdst = 1'b1; e.alu = alu_of(fn); end
      K_IE: begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = (opc == 6'b001101) ? 4'b0001 : 4'b0010; end
      K_IW: e.rw = 1'b1;
      K_BR: begin
        e.srca = 1'b1; e.srcb = 2'b00; e.alu = 4'b0110; e.pcsrc = 2'b01; e.pcen = z;
      end
      K_JP: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.alu = bus.ALUcontrol; c.srca = bus.ALUSrcA; c.srcb = bus.ALUSrcB; c.pcsrc = bus.PCSrc;
    c.pcen = bus.PCEn; c.iord = bus.IorD; c.mrd = bus.MemRead; c.mwr = bus.MemWrite;
    c.irw = bus.IRWrite; c.regdst = bus.RegDst; c.m2r = bus.MemtoReg; c.rw = bus.RegWrite;
    c.ill = bus.Illegal;
    return c;
  endfunction

  // Phase sequence for one instruction; fw/mw are memReady-low cycles in fetch/mem read
  task automatic make_plan(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int mw);
    plan.delete();
    repeat (fw) plan.push_back(K_IF_WAIT);
    plan.push_back(K_IF);
    plan.push_back(K_ID);
    case (opc)
      6'b100011: begin
        plan.push_back(K_MA);
        repeat (mw) plan.push_back(K_MR_WAIT);
        plan.push_back(K_MR);
        plan.push_back(K_MWB);
      end
      6'b101011: begin plan.push_back(K_MA); plan.push_back(K_SW); end
      6'b000000: begin plan.push_back(K_EX); if (fn_ok(fn)) plan.push_back(K_RW); end
      6'b001000, 6'b001101: begin plan.push_back(K_IE); plan.push_back(K_IW); end
      6'b000100: plan.push_back(K_BR);
      6'b000010: plan.push_back(K_JP);
      default: ;
    endcase
  endtask

  // Drive one phase's inputs (don't-care inputs randomised), sample, advance one clock
  task automatic play(input step_e k, input logic [5:0] opc, input logic [5:0] fn, input logic z,
                      output ctl_t got, output ctl_t want);
    bus.memReady = (k == K_IF || k == K_MR) ? 1'b1 :
                   (k == K_IF_WAIT || k == K_MR_WAIT) ? 1'b0 : 1'($urandom);
    bus.Opcode   = (k == K_ID) ? opc : 6'($urandom);
    bus.Funct    = (k == K_EX) ? fn : 6'($urandom);
    bus.isZero   = (k == K_BR) ? z : 1'($urandom);
    #1;
    got  = sample();
    want = exp_of(k, opc, fn, z);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ctl_t got, want;
    bus.Opcode = 6'b111111; bus.Funct = '0; bus.isZero = 1'b1; bus.memReady = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.memReady = (i == 0) ? 1'b1 : 1'($urandom);
      #1;
      got = sample(); want = exp_of(K_IF_WAIT, '0, '0, 1'b0);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_lw();
    ctl_t got, want;
    make_plan(6'b100011, '0, 0, 0);
    foreach (plan[i]) begin
      play(plan[i], 6'b100011, '0, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL lw cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_sw_imm();
    ctl_t got, want;
    logic [5:0] ops[3] = '{6'b101011, 6'b001000, 6'b001101};
    foreach (ops[j]) begin
      make_plan(ops[j], '0, 0, 0);
      foreach (plan[i]) begin
        play(plan[i], ops[j], '0, 1'b0, got, want);
        n_cmp++;
        if (got !== want) begin
          n_bad++; $display("FAIL op%b cyc%0d got=%h want=%h", ops[j], i + 1, got, want);
        end
      end
    end
  endtask

  task automatic test_rtype_sub();
    ctl_t got, want;
    make_plan(6'b000000, 6'b100010, 0, 0);
    foreach (plan[i]) begin
      play(plan[i], 6'b000000, 6'b100010, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL sub cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_beq();
    ctl_t got, want;
    for (int z = 1; z >= 0; z--) begin
      make_plan(6'b000100, '0, 0, 0);
      foreach (plan[i]) begin
        play(plan[i], 6'b000100, '0, 1'(z), got, want);
        n_cmp++;
        if (got !== want) begin
          n_bad++; $display("FAIL beq_z%0d cyc%0d got=%h want=%h", z, i + 1, got, want);
        end
      end
    end
  endtask

  task automatic test_fetch_wait();
    ctl_t got, want;
    make_plan(6'b000010, '0, 3, 0);
    foreach (plan[i]) begin
      play(plan[i], 6'b000010, '0, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL fetch_wait cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_illegal();
    ctl_t got, want;
    make_plan(6'b111111, '0, 0, 0);
    foreach (plan[i]) begin
      play(plan[i], 6'b111111, '0, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL ill_op cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
    make_plan(6'b000000, 6'b000000, 0, 0);
    foreach (plan[i]) begin
      play(plan[i], 6'b000000, 6'b000000, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL ill_fn cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    ctl_t got, want;
    make_plan(6'b101011, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      play(plan[i], 6'b101011, '0, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL sw_pre cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
    bus.memReady = 1'b1; bus.Opcode = 6'($urandom);
    #1;
    got = sample(); want = exp_of(K_SW, '0, '0, 1'b0);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL sw_before_reset got=%h want=%h", got, want);
    end
    rst_n = 1'b0;
    #1;
    got = sample(); want = exp_of(K_IF_WAIT, '0, '0, 1'b0);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_drop got=%h want=%h", got, want);
    end
    @(posedge clk); #1;
    got = sample();
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_hold got=%h want=%h", got, want);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    make_plan(6'b100011, '0, 0, 1);
    foreach (plan[i]) begin
      play(plan[i], 6'b100011, '0, 1'b0, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL after_reset cyc%0d got=%h want=%h", i + 1, got, want);
      end
    end
  endtask

  task automatic test_random();
    ctl_t got, want;
    logic [5:0] opc, fn;
    logic       z;
    logic [5:0] legal_ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                                 6'b001101, 6'b000100, 6'b000010};
    logic [5:0] legal_fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b100111};
    for (int n = 0; n < 60; n++) begin
      opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 6)];
      fn  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 5)];
      z   = 1'($urandom);
      make_plan(opc, fn, $urandom_range(0, 2), $urandom_range(0, 2));
      foreach (plan[i]) begin
        play(plan[i], opc, fn, z, got, want);
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL rnd%0d op%b fn%b cyc%0d got=%h want=%h", n, opc, fn, i + 1, got, want);
        end
        n_cmp++;
        if (got.ill && (got.rw || got.mwr || got.pcen)) begin
          n_bad++; $display("FAIL rnd%0d illegal_with_write got=%h", n, got);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_imm();
    test_rtype_sub();
    test_beq();
    test_fetch_wait();
    test_illegal();
    test_reset_mid_memwr();
    test_random();
    test_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
